// File: rtl/mem_bus_pkg.sv
// Shared definitions for the native memory bus arbiter and its watchdog.
package mem_bus_pkg;

  localparam int unsigned BUS_W = 32;
  localparam logic [BUS_W-1:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // Round-robin pick from IDLE; on a tie the master not served last wins.
  function automatic arb_state_e pick_grant(input logic v0, input logic v1,
                                            input logic last_gnt);
    arb_state_e nxt;
    nxt = IDLE;
    if (v0 && v1) begin
      nxt = last_gnt ? GNT0 : GNT1;
    end else if (v0) begin
      nxt = GNT0;
    end else if (v1) begin
      nxt = GNT1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Access watchdog: flags the cycle in which an active access has waited
// TIMEOUT cycles without ready. A coincident ready always wins.
module bus_watchdog
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic [15:0] count,
  input  logic        start,
  input  logic        ready,
  output logic        expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  always_comb begin
    expire = start & ~ready & (count == LIMIT);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one native memory bus slave between two masters,
// with a watchdog that force-completes accesses the slave never acknowledges.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned       TIMEOUT   = 256,
  parameter logic [BUS_W-1:0]  ERR_RDATA = DEF_ERR_RDATA
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             m0_valid,
  input  logic [BUS_W-1:0] m0_addr,
  input  logic [BUS_W-1:0] m0_wdata,
  input  logic [3:0]       m0_wstrb,
  output logic             m0_ready,
  output logic [BUS_W-1:0] m0_rdata,
  input  logic             m1_valid,
  input  logic [BUS_W-1:0] m1_addr,
  input  logic [BUS_W-1:0] m1_wdata,
  input  logic [3:0]       m1_wstrb,
  output logic             m1_ready,
  output logic [BUS_W-1:0] m1_rdata,
  output logic             s_valid,
  output logic [BUS_W-1:0] s_addr,
  output logic [BUS_W-1:0] s_wdata,
  output logic [3:0]       s_wstrb,
  input  logic             s_ready,
  input  logic [BUS_W-1:0] s_rdata,
  output logic             timeout_err,
  output logic             err_master
);

  arb_state_e  state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        err_master_q, err_master_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;

  logic granted;
  logic sel0;
  logic sel1;
  logic expire;
  logic done;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .count  (wd_cnt_q),
    .start  (granted),
    .ready  (s_ready),
    .expire (expire)
  );

  always_comb begin
    granted = (state_q != IDLE);
    sel0    = (state_q == GNT0);
    sel1    = (state_q == GNT1);
    done    = granted & (s_ready | expire);

    // In IDLE the request lines still follow master 0; only s_valid qualifies them.
    s_valid = granted;
    s_addr  = sel1 ? m1_addr  : m0_addr;
    s_wdata = sel1 ? m1_wdata : m0_wdata;
    s_wstrb = sel1 ? m1_wstrb : m0_wstrb;

    m0_ready = sel0 & (s_ready | expire);
    m1_ready = sel1 & (s_ready | expire);
    m0_rdata = '0;
    m1_rdata = '0;
    if (sel0) begin
      m0_rdata = expire ? ERR_RDATA : s_rdata;
    end
    if (sel1) begin
      m1_rdata = expire ? ERR_RDATA : s_rdata;
    end

    timeout_err = expire;
    err_master  = err_master_q;

    state_d = state_q;
    case (state_q)
      IDLE:       state_d = pick_grant(m0_valid, m1_valid, last_gnt_q);
      GNT0, GNT1: if (done) state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    last_gnt_d   = done   ? sel1 : last_gnt_q;
    err_master_d = expire ? sel1 : err_master_q;
    wd_cnt_d     = (granted & ~s_ready) ? wd_cnt_q + 16'd1 : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_gnt_q   <= 1'b1;
      err_master_q <= 1'b0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      err_master_q <= err_master_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level reference predicts each
// grant, its completion cycle and response; a monitor compares bus activity.
module tb_mem_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        timeout_err, err_master;

  mem_arbiter #(
    .TIMEOUT   (TO),
    .ERR_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m0_valid    (m0_valid),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_wstrb    (m0_wstrb),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_wstrb    (m1_wstrb),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .timeout_err (timeout_err),
    .err_master  (err_master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          m;
    int          start;
    int          due;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  int          next_arb = 0;
  bit          last_m = 1'b1;
  bit          exp_err_m = 1'b0;
  bit          sl_pend = 1'b0;
  int          sl_cyc = 0;
  logic [31:0] sl_data = '0;
  int          force_lat = -1;
  bit          force_data_en = 1'b0;
  logic [31:0] force_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic m_set(input int i, input logic v, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    if (i == 0) begin
      m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
    end else begin
      m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic single(input int i, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws);
    bit got;
    got = 1'b0;
    m_set(i, 1'b1, a, wd, ws);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if ((i == 0) ? m0_ready : m1_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("wait_ready_m%0d", i), 32'(got), 32'd1);
    @(posedge clk); #1;
    m_set(i, 1'b0, '0, '0, '0);
  endtask

  task automatic drive_master(input int i, input int n, input int maxgap);
    logic [31:0] a, wd;
    logic [3:0]  ws;
    int          gap;
    for (int k = 0; k < n; k++) begin
      a  = ($urandom & 32'h00FF_FFFC) | ((i == 1) ? 32'h1000_0000 : 32'h0);
      wd = $urandom;
      ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      single(i, a, wd, ws);
      gap = int'($urandom_range(0, maxgap));
      for (int j = 0; j < gap; j++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Slave: acknowledges on the cycle the reference scheduled, else idles with junk data.
  initial begin
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (sl_pend && cyc == sl_cyc) begin
        s_ready = 1'b1;
        s_rdata = sl_data;
        sl_pend = 1'b0;
      end else begin
        s_ready = 1'b0;
        s_rdata = $urandom;
      end
    end
  end

  // Reference: when the bus is free and someone requests, decide winner, slave
  // latency and outcome, and book the whole access into the scoreboard.
  initial begin
    exp_t        e;
    bit          g;
    int          lat;
    logic [31:0] data;
    forever begin
      @(negedge clk);
      if (resetn && cyc >= next_arb && (m0_valid || m1_valid)) begin
        if (m0_valid && m1_valid) g = ~last_m;
        else                      g = m1_valid;
        if (force_lat >= 0)                  lat = force_lat;
        else if ($urandom_range(0, 3) != 0)  lat = int'($urandom_range(0, 3));
        else                                 lat = int'($urandom_range(4, TO + 2));
        data    = force_data_en ? force_data : $urandom;
        e.m     = g;
        e.start = cyc + 1;
        e.err   = (lat >= TO);
        e.due   = e.err ? cyc + TO : cyc + 1 + lat;
        e.rdata = e.err ? ERR : data;
        e.addr  = g ? m1_addr  : m0_addr;
        e.wdata = g ? m1_wdata : m0_wdata;
        e.wstrb = g ? m1_wstrb : m0_wstrb;
        sb.push_back(e);
        sl_pend  = !e.err;
        sl_cyc   = cyc + 1 + lat;
        sl_data  = data;
        next_arb = e.due + 1;
        last_m   = g;
      end
    end
  end

  // Monitor: compares every cycle against the booked access, if any.
  initial begin
    exp_t        e;
    logic        rdy_g, rdy_o;
    logic [31:0] rd_g, rd_o;
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk("err_master", 32'(err_master), 32'(exp_err_m));
        if (sb.size() != 0 && sb[0].start <= cyc) begin
          e     = sb[0];
          rdy_g = e.m ? m1_ready : m0_ready;
          rdy_o = e.m ? m0_ready : m1_ready;
          rd_g  = e.m ? m1_rdata : m0_rdata;
          rd_o  = e.m ? m0_rdata : m1_rdata;
          chk("s_valid_gnt", 32'(s_valid), 32'd1);
          chk("s_addr", s_addr, e.addr);
          chk("s_wdata", s_wdata, e.wdata);
          chk("s_wstrb", 32'(s_wstrb), 32'(e.wstrb));
          chk("ready_other", 32'(rdy_o), 32'd0);
          chk("rdata_other", rd_o, 32'd0);
          if (cyc == e.due) begin
            chk($sformatf("ready_done_m%0d", e.m), 32'(rdy_g), 32'd1);
            chk("rdata_done", rd_g, e.rdata);
            chk("timeout_err_done", 32'(timeout_err), 32'(e.err));
            if (e.err) exp_err_m = e.m;
            void'(sb.pop_front());
          end else begin
            chk($sformatf("ready_wait_m%0d", e.m), 32'(rdy_g), 32'd0);
            chk("rdata_pass", rd_g, s_rdata);
            chk("timeout_err_wait", 32'(timeout_err), 32'd0);
          end
        end else begin
          chk("s_valid_idle", 32'(s_valid), 32'd0);
          chk("m0_ready_idle", 32'(m0_ready), 32'd0);
          chk("m1_ready_idle", 32'(m1_ready), 32'd0);
          chk("m0_rdata_idle", m0_rdata, 32'd0);
          chk("m1_rdata_idle", m1_rdata, 32'd0);
          chk("timeout_err_idle", 32'(timeout_err), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d: got running, expected finished", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    m_set(0, 1'b0, '0, '0, '0);
    m_set(1, 1'b0, '0, '0, '0);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_err_master", 32'(err_master), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    force_lat = 0; force_data_en = 1'b1; force_data = 32'h1234_5678;
    single(0, 32'h0000_0010, 32'h0, 4'h0);
    force_data_en = 1'b0;

    force_lat = 2;
    fork
      drive_master(0, 4, 0);
      drive_master(1, 4, 0);
    join

    force_lat = 1;
    single(1, 32'h1000_0000, 32'h0000_0041, 4'b0001);

    force_lat = TO + 3;
    single(0, 32'h0000_0020, 32'h0, 4'h0);

    force_lat = TO - 1;
    single(1, 32'h1000_0024, 32'h0, 4'h0);
    single(0, 32'h0000_0024, 32'h5555_AAAA, 4'hF);

    force_lat = -1;
    fork
      drive_master(0, 30, 3);
      drive_master(1, 30, 3);
    join

    force_lat = TO + 1;
    single(1, 32'h1000_0030, 32'h0, 4'h0);

    // Abort a GNT1 wait state with reset; the model forgets the booked access.
    force_lat = TO + 5;
    m_set(1, 1'b1, 32'h1000_0040, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_s_valid", 32'(s_valid), 32'd0);
    chk("arst_m1_ready", 32'(m1_ready), 32'd0);
    chk("arst_m1_rdata", m1_rdata, 32'd0);
    chk("arst_timeout_err", 32'(timeout_err), 32'd0);
    chk("arst_err_master", 32'(err_master), 32'd0);
    sb.delete();
    last_m = 1'b1; next_arb = 0; sl_pend = 1'b0; exp_err_m = 1'b0;
    m_set(1, 1'b0, '0, '0, '0);
    repeat (2) begin
      @(negedge clk);
      chk("arst_hold_m1_ready", 32'(m1_ready), 32'd0);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    force_lat = 1;
    fork
      single(0, 32'h0000_0050, 32'h0, 4'h0);
      single(1, 32'h1000_0050, 32'h0, 4'h0);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("tie_after_reset", s_addr, 32'h0000_0050);
      end
    join

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
